// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART core; the core clock runs at OVERSAMPLE x the bit rate.
// Define UART_LOOPBACK_EN to add a loopback input that routes tx_out into the receiver.
module uart_txrx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
`ifdef UART_LOOPBACK_EN
    input  logic       loopback,
`endif
    input  logic       tx_ld,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_out,
    output logic       tx_empty,
    input  logic       rx_uld,
    output logic [7:0] rx_data,
    input  logic       rx_en,
    input  logic       rx_in,
    output logic       rx_empty,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] PEN  = CW'(OVERSAMPLE - 2);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic            tx_out_q, tx_out_d;
    logic [7:0]      tx_hold_q, tx_hold_d;
    logic            tx_full_q, tx_full_d;

    state_t          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_empty_q, rx_empty_d;
    logic            rx_ferr_q, rx_ferr_d;
    logic            rx_ovr_q, rx_ovr_d;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    logic            rx_line;

    assign tx_out       = tx_out_q;
    assign tx_empty     = ~tx_full_q;
    assign rx_data      = rx_data_q;
    assign rx_empty     = rx_empty_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_overrun   = rx_ovr_q;

    // The holding register stays full for the whole frame so bits are sent straight from it.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_out_d   = tx_out_q;
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;
        if (tx_ld && !tx_full_q) begin
            tx_hold_d = tx_data;
            tx_full_d = 1'b1;
        end
        case (tx_state_q)
            S_IDLE: begin
                if (tx_en && tx_full_q) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    tx_out_d   = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == LAST) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_out_d   = tx_hold_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_out_d = tx_hold_q[tx_bit_q + 3'd1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: begin
                if (tx_cnt_q == PEN) tx_full_d = 1'b0;
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = '0;
                    // A load landing on the last stop clock starts the next frame without idle.
                    if (tx_en && tx_ld) begin
                        tx_state_d = S_START;
                        tx_out_d   = 1'b0;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_out_q   <= 1'b1;
            tx_hold_q  <= 8'h00;
            tx_full_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_out_q   <= tx_out_d;
            tx_hold_q  <= tx_hold_d;
            tx_full_q  <= tx_full_d;
        end
    end

`ifdef UART_LOOPBACK_EN
    assign rx_line = loopback ? tx_out_q : (rx_en ? rx_in : 1'b1);
`else
    assign rx_line = rx_en ? rx_in : 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_line;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Unload is applied first so a completing byte in the same clock overrides it.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_empty_d = rx_empty_q;
        rx_ferr_d  = rx_ferr_q;
        rx_ovr_d   = rx_ovr_q;
        if (rx_uld && !rx_empty_q) begin
            rx_empty_d = 1'b1;
            rx_ovr_d   = 1'b0;
            rx_ferr_d  = 1'b0;
        end
        if (!rx_en) begin
            rx_state_d = S_IDLE;
        end else begin
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_d = S_START;
                        rx_cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == HALF) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = 3'd0;
                        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == LAST) begin
                        rx_cnt_d   = '0;
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                        else                  rx_bit_d   = rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (rx_cnt_q == LAST) begin
                        rx_cnt_d   = '0;
                        rx_state_d = S_IDLE;
                        if (rx_s2_q) begin
                            rx_data_d  = rx_shift_q;
                            rx_empty_d = 1'b0;
                            if (!rx_empty_q && !rx_uld) rx_ovr_d = 1'b1;
                        end else begin
                            rx_ferr_d = 1'b1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_empty_q <= 1'b1;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_empty_q <= rx_empty_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: TX waveform, reset abort, external loopback, RX error paths.
module tb_uart_txrx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_ld = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_en = 1'b1;
    logic       tx_out, tx_empty;
    logic       rx_uld = 1'b0;
    logic [7:0] rx_data;
    logic       rx_en = 1'b0;
    logic       rx_in;
    logic       rx_empty, rx_frame_err, rx_overrun;
    logic       lb_sel = 1'b0;
    logic       rx_drv = 1'b1;

    int compared = 0;
    int mismatched = 0;

    assign rx_in = lb_sel ? tx_out : rx_drv;

    always #5 clk = ~clk;

    uart_txrx #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_ld(tx_ld), .tx_data(tx_data), .tx_en(tx_en),
        .tx_out(tx_out), .tx_empty(tx_empty),
        .rx_uld(rx_uld), .rx_data(rx_data), .rx_en(rx_en), .rx_in(rx_in),
        .rx_empty(rx_empty), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tx_frame(input logic [7:0] d, input bit drop_en);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        tx_data = d;
        tx_ld = 1'b1;
        @(negedge clk);
        tx_ld = 1'b0;
        check("tx_empty_after_ld", 32'(tx_empty), 32'd0);
        for (int i = 0; i < 10 * OS; i++) begin
            @(negedge clk);
            if (drop_en && i == 5 * OS) tx_en = 1'b0;
            if (i % OS == 0 || i % OS == OS - 1) check("tx_bit", 32'(tx_out), 32'(fr[i / OS]));
            if (i == 10 * OS - 2) check("tx_empty_pen", 32'(tx_empty), 32'd0);
            if (i == 10 * OS - 1) check("tx_empty_last", 32'(tx_empty), 32'd1);
        end
        tx_en = 1'b1;
        @(negedge clk);
        check("tx_idle_after", 32'(tx_out), 32'd1);
    endtask

    task automatic tx_load(input logic [7:0] d);
        int t;
        t = 0;
        while (!tx_empty && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!tx_empty) check("tx_empty_wait", 32'(tx_empty), 32'd1);
        tx_data = d;
        tx_ld = 1'b1;
        @(negedge clk);
        tx_ld = 1'b0;
    endtask

    task automatic wait_rx();
        int t;
        t = 0;
        while (rx_empty && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("rx_got_byte", 32'(rx_empty), 32'd0);
    endtask

    task automatic unload();
        rx_uld = 1'b1;
        @(negedge clk);
        rx_uld = 1'b0;
        check("uld_empty", 32'(rx_empty), 32'd1);
    endtask

    task automatic drive_bit(input logic v);
        rx_drv = v;
        repeat (OS) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stopb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stopb);
        drive_bit(1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_tx_out", 32'(tx_out), 32'd1);
        check("rst_tx_empty", 32'(tx_empty), 32'd1);
        check("rst_rx_empty", 32'(rx_empty), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_ferr", 32'(rx_frame_err), 32'd0);
        check("rst_ovr", 32'(rx_overrun), 32'd0);

        // 0xA5 waveform, with tx_en dropped mid-frame
        tx_frame(8'hA5, 1'b1);

        // Reset during bit 3 of 0x5A, then a clean frame
        tx_data = 8'h5A;
        tx_ld = 1'b1;
        @(negedge clk);
        tx_ld = 1'b0;
        repeat (1 + 4 * OS + 4) @(negedge clk);
        check("pre_rst_busy", 32'(tx_empty), 32'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_tx_out", 32'(tx_out), 32'd1);
        check("midrst_tx_empty", 32'(tx_empty), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tx_frame(8'h5A, 1'b0);

        // External loopback of random bytes
        lb_sel = 1'b1;
        rx_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom_range(0, 255));
            tx_load(d);
            wait_rx();
            check("lb_data", 32'(rx_data), 32'(d));
            check("lb_ferr", 32'(rx_frame_err), 32'd0);
            check("lb_ovr", 32'(rx_overrun), 32'd0);
            unload();
        end

        // Back-to-back frames with no unload -> overrun
        tx_load(8'h11);
        tx_load(8'h22);
        check("b2b_start", 32'(tx_out), 32'd0);
        repeat (12 * OS) @(negedge clk);
        check("ovr_data", 32'(rx_data), 32'h22);
        check("ovr_flag", 32'(rx_overrun), 32'd1);
        check("ovr_not_empty", 32'(rx_empty), 32'd0);
        unload();
        check("ovr_cleared", 32'(rx_overrun), 32'd0);

        // Bad stop bit on 0x3C
        lb_sel = 1'b0;
        rx_drv = 1'b1;
        repeat (OS) @(negedge clk);
        drive_frame(8'h3C, 1'b0);
        check("ferr_flag", 32'(rx_frame_err), 32'd1);
        check("ferr_empty", 32'(rx_empty), 32'd1);
        check("ferr_data_kept", 32'(rx_data), 32'h22);

        do_reset();
        check("rst2_ferr", 32'(rx_frame_err), 32'd0);
        check("rst2_data", 32'(rx_data), 32'h00);

        // Short low glitch must be rejected as a false start
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * OS) @(negedge clk);
        check("glitch_empty", 32'(rx_empty), 32'd1);
        check("glitch_ferr", 32'(rx_frame_err), 32'd0);
        check("glitch_ovr", 32'(rx_overrun), 32'd0);

        // rx_en dropped during bit 4 of 0x77
        d = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) rx_en = 1'b0;
            drive_bit(d[i]);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx_en = 1'b1;
        repeat (2 * OS) @(negedge clk);
        check("abort_empty", 32'(rx_empty), 32'd1);
        check("abort_data", 32'(rx_data), 32'h00);
        check("abort_ferr", 32'(rx_frame_err), 32'd0);

        // Good externally driven frame
        drive_frame(8'h3C, 1'b1);
        check("ext_data", 32'(rx_data), 32'h3C);
        check("ext_empty", 32'(rx_empty), 32'd0);
        check("ext_ferr", 32'(rx_frame_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
